multi_edge_detect: RTL

Parametrised multi-channel edge detector for the button and switch front end. Each channel synchronises an asynchronous input, optionally debounces it, and produces registered single-cycle rise, fall and mode-selected event pulses, plus the clean level. It replaces the single-channel rising-edge detector between the board inputs and the stopwatch/watch control FSMs, so all buttons share one block.

---
 rtl/multi_edge_detect.sv | 112 +++++++++++
 1 files changed

// File: rtl/multi_edge_detect.sv
// Multi-channel synchroniser and edge detector with registered rise/fall/mode pulses.
// Optional per-channel debounce is built only when EDGE_DEBOUNCE_EN is defined.
module multi_edge_detect #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int DB_CNT      = 100_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] i_pulse,
    output logic [CH-1:0] o_level,
    output logic [CH-1:0] o_rise,
    output logic [CH-1:0] o_fall,
    output logic [CH-1:0] o_pulse
);

    // Unsupported MODE values fall back to rising-edge reporting.
    localparam int MODE_EFF = (MODE == 1 || MODE == 2) ? MODE : 0;

    if (CH < 1 || CH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_CNT < 2) begin : g_bad_param
        $error("multi_edge_detect: parameter out of range");
    end

    logic [CH-1:0] r_sync [SYNC_STAGES];
    logic [CH-1:0] w_sync;
    logic [CH-1:0] w_level;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= i_pulse;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int                CNT_W   = $clog2(DB_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

    logic [CNT_W-1:0] r_cnt [CH];
    logic [CH-1:0]    r_level;

    // NOTE: the counter array is small and must restart cleanly, so it is reset like any other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            for (int c = 0; c < CH; c++) r_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (w_sync[c] == r_level[c]) begin
                    r_cnt[c] <= '0;
                end else if (r_cnt[c] == CNT_MAX) begin
                    r_level[c] <= ~r_level[c];
                    r_cnt[c]   <= '0;
                end else begin
                    r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    assign w_level = r_level;
`else
    assign w_level = w_sync;
`endif

    logic [CH-1:0] r_prev;
    logic [CH-1:0] r_rise;
    logic [CH-1:0] r_fall;
    logic [CH-1:0] r_pulse;
    logic [CH-1:0] w_rise_n;
    logic [CH-1:0] w_fall_n;
    logic [CH-1:0] w_pulse_n;

    assign w_rise_n = w_level & ~r_prev;
    assign w_fall_n = ~w_level & r_prev;

    // NOTE: always_comb outputs get a default first so no path can infer a latch.
    always_comb begin
        w_pulse_n = w_rise_n;
        case (MODE_EFF)
            1:       w_pulse_n = w_fall_n;
            2:       w_pulse_n = w_rise_n | w_fall_n;
            default: w_pulse_n = w_rise_n;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_pulse <= '0;
        end else begin
            r_prev  <= w_level;
            r_rise  <= w_rise_n;
            r_fall  <= w_fall_n;
            r_pulse <= w_pulse_n;
        end
    end

    assign o_level = w_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_pulse = r_pulse;

endmodule
